// File: rtl/ysyx_25060170_dmem_responder_if.sv
// LSU <-> data-memory responder bus.
// master: LSU side (drives request and core_ready).
// slave:  responder side (drives response and busy).
interface ysyx_25060170_dmem_responder_if;
  logic        re;
  logic        we;
  logic [63:0] data_pc;
  logic [63:0] wdata;
  logic [7:0]  wlen;
  logic [2:0]  data_size;
  logic        core_ready;
  logic [63:0] data_temp;
  logic        data_valid;
  logic        resp_err;
  logic        busy;

  modport master (
    output re, we, data_pc, wdata, wlen, data_size, core_ready,
    input  data_temp, data_valid, resp_err, busy
  );

  modport slave (
    input  re, we, data_pc, wdata, wlen, data_size, core_ready,
    output data_temp, data_valid, resp_err, busy
  );
endinterface

// File: rtl/ysyx_25060170_dmem_responder.sv
// Data-memory responder behind the LSU data port.
// Holds a DEPTH x 64-bit word RAM and answers each accepted request with the
// whole aligned doubleword after a programmable latency, using a
// data_valid / core_ready hold handshake. The LSU does lane extraction.
//
// Optional: define YSYX_25060170_DMEM_RAND_LAT_EN to add 0..7 pseudo-random
// extra wait cycles per request (16-bit LFSR), to stress LSU stall paths.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request in flight; accept re|we and capture the request
// WAIT  | latency down-counter running; access happens on cnt==1 edge
// RESP  | response registered; hold until core_ready handshake
module ysyx_25060170_dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned AW      = 10,
  parameter int unsigned LATENCY = 2
) (
  input logic clk,
  input logic rst,
  ysyx_25060170_dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt, cnt_load;
  logic        accept, fire, handshake;

  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wlen;
  logic [2:0]  req_size;

  logic [AW-1:0] req_idx;
  logic [2:0]    align_mask;
  logic          req_err;
  logic [63:0]   rd_word, wr_word;

  logic [63:0] mem [DEPTH];

  logic [63:0] data_temp_q;
  logic        data_valid_q;
  logic        resp_err_q;
  logic        busy_q;

`ifdef YSYX_25060170_DMEM_RAND_LAT_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Free-running LFSR, stepping every cycle
  always_ff @(posedge clk) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // +1 so the counter always has at least one WAIT cycle to terminate on
  assign cnt_load = 5'(LATENCY) + 5'd1 + {2'b00, lfsr[2:0]};
`else
  // +1 so the counter always has at least one WAIT cycle to terminate on
  assign cnt_load = 5'(LATENCY) + 5'd1;
`endif

  // State register and latency down-counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic and the accept / fire / handshake strobes
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    fire      = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (bus.re || bus.we) begin
          accept    = 1'b1;
          cnt_nxt   = cnt_load;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 5'd1) begin
          fire      = 1'b1;
          cnt_nxt   = 5'd0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      RESP: begin
        if (bus.core_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request on accept; the LSU may drop its inputs afterwards
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_we    <= 1'b0;
      req_addr  <= 64'd0;
      req_wdata <= 64'd0;
      req_wlen  <= 8'd0;
      req_size  <= 3'd0;
    end else if (accept) begin
      req_we    <= bus.we;
      req_addr  <= bus.data_pc;
      req_wdata <= bus.wdata;
      req_wlen  <= bus.wlen;
      req_size  <= bus.data_size;
    end
  end

  assign req_idx = req_addr[AW+2:3];

  // Low address bits that must be zero for the requested access size
  always_comb begin
    case (req_size[1:0])
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign req_err = req_size[2]
                 | (|(req_addr[2:0] & align_mask))
                 | (|req_addr[63:AW+3]);

  assign rd_word = mem[req_idx];

  // Byte-strobe merge of write data over the current word
  always_comb begin
    wr_word = rd_word;
    for (int i = 0; i < 8; i++) begin
      if (req_wlen[i]) wr_word[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  // RAM write: only on a clean fire edge, so a reset discards pending writes
  always_ff @(posedge clk) begin
    if (rst && fire && req_we && !req_err) mem[req_idx] <= wr_word;
  end

  // Response registers: load on fire, hold through RESP, clear on handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_temp_q  <= 64'd0;
      data_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      if (fire) begin
        data_valid_q <= 1'b1;
        resp_err_q   <= req_err;
        data_temp_q  <= req_err ? 64'd0 : rd_word;
      end else if (handshake) begin
        data_valid_q <= 1'b0;
        resp_err_q   <= 1'b0;
      end
    end
  end

  assign bus.data_temp  = data_temp_q;
  assign bus.data_valid = data_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ysyx_25060170_dmem_responder.sv
// Bench for the data-memory responder. Three instances with LATENCY 2, 4
// and 0 share one driver; only the selected instance sees re/we.
module tb_ysyx_25060170_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        d_re, d_we, d_ready;
  logic [63:0] d_pc, d_wdata;
  logic [7:0]  d_wlen;
  logic [2:0]  d_size;
  int          sel;

  logic [63:0] o_dt_a [3];
  logic        o_dv_a [3];
  logic        o_er_a [3];
  logic        o_bs_a [3];

  for (genvar g = 0; g < 3; g++) begin : gd
    ysyx_25060170_dmem_responder_if bif ();
    assign bif.re         = d_re && (sel == g);
    assign bif.we         = d_we && (sel == g);
    assign bif.data_pc    = d_pc;
    assign bif.wdata      = d_wdata;
    assign bif.wlen       = d_wlen;
    assign bif.data_size  = d_size;
    assign bif.core_ready = d_ready;
    ysyx_25060170_dmem_responder #(
      .DEPTH(DEPTH), .AW(AW), .LATENCY(g == 0 ? 2 : (g == 1 ? 4 : 0))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bif)
    );
    assign o_dt_a[g] = bif.data_temp;
    assign o_dv_a[g] = bif.data_valid;
    assign o_er_a[g] = bif.resp_err;
    assign o_bs_a[g] = bif.busy;
  end

  logic [63:0] o_data;
  logic        o_valid, o_err, o_busy;
  assign o_data  = o_dt_a[sel];
  assign o_valid = o_dv_a[sel];
  assign o_err   = o_er_a[sel];
  assign o_busy  = o_bs_a[sel];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : ((s == 1) ? 4 : 0);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One full transaction: accept, wait for data_valid, stall, handshake.
  task automatic txn(input int s, input logic w, input logic r,
                     input logic [63:0] pc, input logic [63:0] wd,
                     input logic [7:0] wl, input logic [2:0] sz,
                     input int stall, input logic drop,
                     output logic [63:0] dt, output logic er);
    int  lat;
    bit  seen;
    @(negedge clk);
    sel = s; d_we = w; d_re = r; d_pc = pc; d_wdata = wd; d_wlen = wl;
    d_size = sz; d_ready = 1'b0;
    lat = -1;
    seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        chk("busy after accept", 64'(o_busy), 64'd1);
        if (drop) begin d_we = 1'b0; d_re = 1'b0; end
      end
      if (o_valid) begin
        seen = 1;
        lat = k - 1;
      end
    end
    chk("latency", 64'(lat), 64'(lat_of(s) + 1));
    dt = o_data;
    er = o_err;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("stall valid hold", 64'(o_valid), 64'd1);
      chk("stall data hold", o_data, dt);
      chk("stall err hold", 64'(o_err), 64'(er));
    end
    d_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid after handshake", 64'(o_valid), 64'd0);
    chk("busy after handshake", 64'(o_busy), 64'd0);
    d_re = 1'b0; d_we = 1'b0; d_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    int          s;
    logic        w;
    logic        r;
    logic [63:0] pc;
    logic [63:0] wd;
    logic [7:0]  wl;
    logic [2:0]  sz;
    int          stall;
    logic        chk_d;
    logic [63:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] mdl [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got_d;
    logic        got_e;

    tbl.push_back('{"wr full 0x10",    0, 1'b1, 1'b0, 64'h10, 64'h1122334455667788, 8'hFF, 3'd3, 0, 1'b0, 64'h0, 1'b0});
    tbl.push_back('{"rd 0x10",         0, 1'b0, 1'b1, 64'h10, 64'h0, 8'h00, 3'd3, 0, 1'b1, 64'h1122334455667788, 1'b0});
    tbl.push_back('{"wr byte 0x13",    0, 1'b1, 1'b0, 64'h13, 64'hAB000000, 8'h08, 3'd0, 0, 1'b1, 64'h1122334455667788, 1'b0});
    tbl.push_back('{"rd backpressure", 0, 1'b0, 1'b1, 64'h10, 64'h0, 8'h00, 3'd3, 5, 1'b1, 64'h11223344AB667788, 1'b0});
    tbl.push_back('{"wr full 0x0",     0, 1'b1, 1'b0, 64'h0, 64'hCAFEF00DDEADBEEF, 8'hFF, 3'd3, 0, 1'b0, 64'h0, 1'b0});
    tbl.push_back('{"rd misaligned",   0, 1'b0, 1'b1, 64'h12, 64'h0, 8'h00, 3'd2, 0, 1'b1, 64'h0, 1'b1});
    tbl.push_back('{"wr out of range", 0, 1'b1, 1'b0, 64'(DEPTH*8), 64'hFFFFFFFFFFFFFFFF, 8'hFF, 3'd3, 0, 1'b1, 64'h0, 1'b1});
    tbl.push_back('{"rd idx0 intact",  0, 1'b0, 1'b1, 64'h0, 64'h0, 8'h00, 3'd3, 0, 1'b1, 64'hCAFEF00DDEADBEEF, 1'b0});
    tbl.push_back('{"rd bad size",     0, 1'b0, 1'b1, 64'h0, 64'h0, 8'h00, 3'd5, 1, 1'b1, 64'h0, 1'b1});
    tbl.push_back('{"lat4 wr 0x28",    1, 1'b1, 1'b0, 64'h28, 64'h0123456789ABCDEF, 8'hFF, 3'd3, 0, 1'b0, 64'h0, 1'b0});
    tbl.push_back('{"lat0 wr 0x0",     2, 1'b1, 1'b0, 64'h0, 64'h0, 8'hFF, 3'd3, 0, 1'b0, 64'h0, 1'b0});
    tbl.push_back('{"lat0 re+we",      2, 1'b1, 1'b1, 64'h0, 64'h5A, 8'h01, 3'd0, 0, 1'b1, 64'h0, 1'b0});
    tbl.push_back('{"lat0 rd 0x0",     2, 1'b0, 1'b1, 64'h0, 64'h0, 8'h00, 3'd3, 0, 1'b1, 64'h5A, 1'b0});

    rst = 1'b0; sel = 0;
    d_re = 1'b0; d_we = 1'b0; d_ready = 1'b0;
    d_pc = 64'd0; d_wdata = 64'd0; d_wlen = 8'd0; d_size = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset data_valid", 64'(o_valid), 64'd0);
    chk("reset resp_err", 64'(o_err), 64'd0);
    chk("reset data_temp", o_data, 64'd0);
    chk("reset busy", 64'(o_busy), 64'd0);
    @(negedge clk) rst = 1'b1;

    foreach (tbl[i]) begin
      txn(tbl[i].s, tbl[i].w, tbl[i].r, tbl[i].pc, tbl[i].wd, tbl[i].wl,
          tbl[i].sz, tbl[i].stall, 1'b0, got_d, got_e);
      if (tbl[i].chk_d) chk({tbl[i].name, " data"}, got_d, tbl[i].exp_d);
      chk({tbl[i].name, " err"}, 64'(got_e), 64'(tbl[i].exp_e));
    end

    // Reset while a LATENCY=4 write is still counting down
    @(negedge clk);
    sel = 1; d_we = 1'b1; d_re = 1'b0; d_pc = 64'h28;
    d_wdata = 64'hDEADDEADDEADDEAD; d_wlen = 8'hFF; d_size = 3'd3;
    @(posedge clk); #1;
    chk("midwait busy before reset", 64'(o_busy), 64'd1);
    d_we = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midwait valid after reset", 64'(o_valid), 64'd0);
    chk("midwait busy after reset", 64'(o_busy), 64'd0);
    @(negedge clk) rst = 1'b1;
    txn(1, 1'b0, 1'b1, 64'h28, 64'h0, 8'h00, 3'd3, 0, 1'b0, got_d, got_e);
    chk("midwait word retained", got_d, 64'h0123456789ABCDEF);
    chk("midwait read err", 64'(got_e), 64'd0);

    // Random traffic on the LATENCY=2 instance against a word-array model
    for (int i = 0; i < 16; i++) begin
      mdl[i] = {$urandom, $urandom};
      txn(0, 1'b1, 1'b0, 64'(i) * 64'd8, mdl[i], 8'hFF, 3'd3, 0, 1'b0, got_d, got_e);
    end
    for (int n = 0; n < 150; n++) begin
      int          idx, lowb;
      logic [63:0] pc, wd, exp_d;
      logic [7:0]  wl;
      logic [2:0]  sz;
      logic        w, r, exp_e, drop;
      idx  = $urandom_range(0, 15);
      sz   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      lowb = $urandom_range(0, 7);
      if ($urandom_range(0, 2) != 0 && sz < 4) lowb = lowb & ~((1 << sz) - 1);
      pc = 64'(idx) * 64'd8 + 64'(lowb);
      if ($urandom_range(0, 9) == 0) pc = pc | (64'd1 << $urandom_range(AW + 3, 63));
      w    = 1'($urandom_range(0, 1));
      r    = w ? 1'($urandom_range(0, 1)) : 1'b1;
      wd   = {$urandom, $urandom};
      wl   = 8'($urandom);
      drop = ($urandom_range(0, 3) == 0);
      exp_e = (sz > 3) || (pc >= 64'(DEPTH * 8)) || ((pc % (64'd1 << sz)) != 0);
      exp_d = exp_e ? 64'd0 : mdl[idx];
      txn(0, w, r, pc, wd, wl, sz, $urandom_range(0, 3), drop, got_d, got_e);
      chk("rand data", got_d, exp_d);
      chk("rand err", 64'(got_e), 64'(exp_e));
      if (!exp_e && w) begin
        for (int b = 0; b < 8; b++)
          if (wl[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
